// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller clocked by the core clock; tck is oversampled and edge-detected.
// Define JTAG_TAP_STATE_OBS_EN to export the FSM encoding on tap_state.
module jtag_tap_ctrl #(
    parameter int          IR_W        = 4,
    parameter int          DR_W        = 32,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tck,
    input  logic            tms,
    input  logic            tdi,
    input  logic            trst,
    output logic            tdo,
    output logic            tdo_en,
    input  logic [DR_W-1:0] dbg_din,
    output logic [DR_W-1:0] dbg_dout,
    output logic            dbg_update,
    output logic            dbg_capture
`ifdef JTAG_TAP_STATE_OBS_EN
    ,
    output logic [3:0]      tap_state
`endif
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,
        SEL_DR = 4'd2,  CAP_DR = 4'd3,  SH_DR  = 4'd4,  EX1_DR = 4'd5,
        PA_DR  = 4'd6,  EX2_DR = 4'd7,  UPD_DR = 4'd8,
        SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11, EX1_IR = 4'd12,
        PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] IR_DBG    = IR_W'(8);

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic                   tck_d;
    logic                   tck_s, tms_s, tdi_s, trst_s;
    logic                   tck_rise, tck_fall;

    tap_state_e state_q, state_d;

    logic [IR_W-1:0] ir, ir_sr;
    logic [31:0]     id_sr;
    logic [DR_W-1:0] dbg_sr;
    logic            byp_sr;
    logic            upd_pend;
    logic            sel_id, sel_dbg, dr_lsb;

    // tms/tdi come from the same stage as tck so they line up with the detected edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_d     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst};
            tck_d     <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign trst_s   = trst_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_d;
    assign tck_fall = ~tck_s & tck_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= TLR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (trst_s) begin
            state_d = TLR;
        end else if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s ? TLR    : RTI;
                RTI:     state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s ? UPD_DR : PA_DR;
                PA_DR:   state_d = tms_s ? EX2_DR : PA_DR;
                EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s ? UPD_IR : PA_IR;
                PA_IR:   state_d = tms_s ? EX2_IR : PA_IR;
                EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    // Unknown instruction codes fall through to BYPASS
    assign sel_id  = (ir == IR_IDCODE);
    assign sel_dbg = (ir == IR_DBG);

    always_comb begin
        dr_lsb = byp_sr;
        if (sel_id)       dr_lsb = id_sr[0];
        else if (sel_dbg) dr_lsb = dbg_sr[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir          <= IR_IDCODE;
            ir_sr       <= '0;
            id_sr       <= '0;
            dbg_sr      <= '0;
            byp_sr      <= 1'b0;
            dbg_dout    <= '0;
            upd_pend    <= 1'b0;
            dbg_update  <= 1'b0;
            dbg_capture <= 1'b0;
            tdo         <= 1'b0;
            tdo_en      <= 1'b0;
        end else if (trst_s) begin
            ir          <= IR_IDCODE;
            upd_pend    <= 1'b0;
            dbg_update  <= 1'b0;
            dbg_capture <= 1'b0;
            tdo         <= 1'b0;
            tdo_en      <= 1'b0;
        end else begin
            dbg_capture <= 1'b0;
            upd_pend    <= 1'b0;
            dbg_update  <= upd_pend;
            if (tck_rise) begin
                case (state_q)
                    CAP_IR: ir_sr <= IR_W'(1);
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
                    UPD_IR: ir    <= ir_sr;
                    CAP_DR: begin
                        if (sel_id) begin
                            id_sr <= IDCODE_VAL;
                        end else if (sel_dbg) begin
                            dbg_sr      <= dbg_din;
                            dbg_capture <= 1'b1;
                        end else begin
                            byp_sr <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (sel_id)       id_sr  <= {tdi_s, id_sr[31:1]};
                        else if (sel_dbg) dbg_sr <= {tdi_s, dbg_sr[DR_W-1:1]};
                        else              byp_sr <= tdi_s;
                    end
                    UPD_DR: begin
                        if (sel_dbg) begin
                            dbg_dout <= dbg_sr;
                            upd_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (state_d == TLR) ir <= IR_IDCODE;
            end
            // tdo changes on the falling edge so the host samples a stable bit on the next rise
            if (tck_fall) begin
                tdo_en <= (state_q == SH_IR) || (state_q == SH_DR);
                if (state_q == SH_IR)      tdo <= ir_sr[0];
                else if (state_q == SH_DR) tdo <= dr_lsb;
                else                       tdo <= 1'b0;
            end
        end
    end

`ifdef JTAG_TAP_STATE_OBS_EN
    assign tap_state = state_q;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: table of IR/DR scans plus pause, TLR and trst sequences.
module tb_jtag_tap_ctrl;

    logic        clk = 1'b0, rst = 1'b1;
    logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0, trst = 1'b0;
    logic        tdo, tdo_en, dbg_update, dbg_capture;
    logic [31:0] dbg_din = '0;
    logic [31:0] dbg_dout;
`ifdef JTAG_TAP_STATE_OBS_EN
    logic [3:0]  tap_state;
`endif

    int checks = 0, failures = 0;
    int upd_cycles = 0, cap_cycles = 0;

    jtag_tap_ctrl dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst),
        .tdo(tdo), .tdo_en(tdo_en), .dbg_din(dbg_din), .dbg_dout(dbg_dout),
        .dbg_update(dbg_update), .dbg_capture(dbg_capture)
`ifdef JTAG_TAP_STATE_OBS_EN
        , .tap_state(tap_state)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dbg_update)  upd_cycles++;
        if (dbg_capture) cap_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  ir;
        logic [31:0] din;
        logic [31:0] tdi_w;
        logic [31:0] exp_tdo;
        logic [31:0] exp_dout;
        int          exp_cap;
        int          exp_upd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one tck period, high and low phases both well above SYNC_STAGES+2 clocks
    task automatic tck_cycle(input logic m, input logic d);
        tms = m;
        tdi = d;
        clks(2);
        tck = 1'b1;
        clks(6);
        tck = 1'b0;
        clks(6);
    endtask

    // tdo is sampled before each rise; the last bit leaves Shift with tms=1
    task automatic shift_bits(input int n, input logic [31:0] vin, output logic [31:0] vout);
        vout = '0;
        for (int i = 0; i < n; i++) begin
            vout[i] = tdo;
            tck_cycle(i == n - 1, vin[i]);
        end
    endtask

    task automatic ir_scan(input logic [3:0] ir, output logic [3:0] cap);
        logic [31:0] v;
        tck_cycle(1, 0);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        shift_bits(4, {28'b0, ir}, v);
        cap = v[3:0];
        tck_cycle(1, 0);
        tck_cycle(0, 0);
    endtask

    task automatic dr_scan(input logic [31:0] vin, output logic [31:0] vout);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        check("tdo_en_in_shift_dr", {31'b0, tdo_en}, 32'd1);
        shift_bits(32, vin, vout);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
    endtask

    initial begin
        logic [3:0]  irc;
        logic [31:0] r1, r2, w;

        vecs[0] = '{4'h1, 32'h0,         32'h0,         32'h1000_0001, 32'h0,         0, 0};
        vecs[1] = '{4'h8, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 1, 1};
        vecs[2] = '{4'h8, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         1, 1};
        vecs[3] = '{4'h5, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h4B4A_1E1E, 32'h0,         0, 0};
        vecs[4] = '{4'hF, 32'h0,         32'h0000_000D, 32'h0000_001A, 32'h0,         0, 0};
        vecs[5] = '{4'h8, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 1, 1};

        clks(3);
        check("rst_tdo",         {31'b0, tdo},         32'd0);
        check("rst_tdo_en",      {31'b0, tdo_en},      32'd0);
        check("rst_dbg_dout",    dbg_dout,             32'd0);
        check("rst_dbg_update",  {31'b0, dbg_update},  32'd0);
        check("rst_dbg_capture", {31'b0, dbg_capture}, 32'd0);
        rst = 1'b0;
        clks(2);

        repeat (5) tck_cycle(1, 0);
        check("tlr_tdo",    {31'b0, tdo},    32'd0);
        check("tlr_tdo_en", {31'b0, tdo_en}, 32'd0);
`ifdef JTAG_TAP_STATE_OBS_EN
        check("tlr_state", {28'b0, tap_state}, 32'd0);
`endif
        tck_cycle(0, 0);

        for (int k = 0; k < 6; k++) begin
            ir_scan(vecs[k].ir, irc);
            check($sformatf("v%0d_ir_capture", k), {28'b0, irc}, 32'h1);
            dbg_din    = vecs[k].din;
            upd_cycles = 0;
            cap_cycles = 0;
            dr_scan(vecs[k].tdi_w, w);
            clks(3);
            check($sformatf("v%0d_tdo_word", k),   w,          vecs[k].exp_tdo);
            check($sformatf("v%0d_dbg_dout", k),   dbg_dout,   vecs[k].exp_dout);
            check($sformatf("v%0d_capture_clks", k), cap_cycles, vecs[k].exp_cap);
            check($sformatf("v%0d_update_clks", k),  upd_cycles, vecs[k].exp_upd);
            check($sformatf("v%0d_tdo_after", k),    {31'b0, tdo},    32'd0);
            check($sformatf("v%0d_tdo_en_after", k), {31'b0, tdo_en}, 32'd0);
        end

        // Pause-DR in the middle of a DBG_DATA shift must not recapture
        ir_scan(4'h8, irc);
        dbg_din    = 32'hCAFE_F00D;
        upd_cycles = 0;
        cap_cycles = 0;
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        shift_bits(16, 32'h0123_4567, r1);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        check("pause_tdo",    {31'b0, tdo},    32'd0);
        check("pause_tdo_en", {31'b0, tdo_en}, 32'd0);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        shift_bits(16, 32'h0000_0123, r2);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        clks(3);
        check("pause_tdo_word",     {r2[15:0], r1[15:0]}, 32'hCAFE_F00D);
        check("pause_dbg_dout",     dbg_dout,   32'h0123_4567);
        check("pause_capture_clks", cap_cycles, 1);
        check("pause_update_clks",  upd_cycles, 1);

        // Five tms=1 from Shift-IR reach TLR and restore IDCODE
        tck_cycle(1, 0);
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 1);
        tck_cycle(0, 0);
        repeat (5) tck_cycle(1, 0);
`ifdef JTAG_TAP_STATE_OBS_EN
        check("tms5_state", {28'b0, tap_state}, 32'd0);
`endif
        tck_cycle(0, 0);
        dr_scan(32'h0, w);
        check("tms5_idcode", w, 32'h1000_0001);

        // trst in the middle of a DBG_DATA shift
        ir_scan(4'h8, irc);
        dbg_din    = 32'h5555_AAAA;
        upd_cycles = 0;
        tck_cycle(1, 0);
        tck_cycle(0, 0);
        tck_cycle(0, 0);
        repeat (10) tck_cycle(0, 1);
        check("trst_pre_tdo_en", {31'b0, tdo_en}, 32'd1);
        trst = 1'b1;
        clks(3);
        check("trst_tdo_en", {31'b0, tdo_en}, 32'd0);
        check("trst_tdo",    {31'b0, tdo},    32'd0);
`ifdef JTAG_TAP_STATE_OBS_EN
        check("trst_state", {28'b0, tap_state}, 32'd0);
`endif
        tck_cycle(0, 1);
        tck_cycle(0, 1);
        trst = 1'b0;
        clks(4);
        check("trst_update_clks", upd_cycles, 0);
        check("trst_dbg_dout",    dbg_dout,   32'h0123_4567);
        tck_cycle(0, 0);
        dr_scan(32'h0, w);
        check("trst_idcode", w, 32'h1000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
